sha_block_fifo: RTL and testbench
=================================

Name: sha_block_fifo

Overview:
Parametrised multi-entry message-block buffer. It replaces the single-entry 352-bit block register between the Compact Message Expander front end and the SHA-256 round cores.
- Stores up to DEPTH blocks of BLOCK_W bits in FIFO order.
- Uses valid/ready handshakes on both sides, so the producer can run ahead of a stalled compression core.
- Provides a synchronous flush for nonce-restart events.

Parameters:
BLOCK_W, 352, width of one stored block in bits (512 for a full SHA-256 block).
DEPTH, 4, number of entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
CLK  input  1  system clock, all state updates on the rising edge.
RST  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush, active high.
wr_valid  input  1  producer offers block_in.
wr_ready  output  1  FIFO can accept a write this cycle.
block_in  input  BLOCK_W  block to store.
rd_valid  output  1  block_out holds a valid head entry.
rd_ready  input  1  consumer takes the head entry this cycle.
block_out  output  BLOCK_W  head-of-FIFO block.
count  output  AW+1  number of stored entries, 0..DEPTH.
overflow  output  1  sticky flag: wr_valid was high while wr_ready was low.

Behaviour:
- Reset (RST=0, asynchronous):
  - wr_ptr, rd_ptr, count and overflow go to 0.
  - All storage entries go to 0.
  - Outputs: wr_ready=1, rd_valid=0, block_out=0.
- Write acceptance: a write happens when wr_valid && wr_ready.
  - block_in is stored at mem[wr_ptr] and wr_ptr increments.
- wr_ready = (count != DEPTH).
  - It is purely registered-state based and never depends on rd_ready in the same cycle (no combinational ready path).
- Read: a read happens when rd_valid && rd_ready, and rd_ptr increments.
- rd_valid = (count != 0).
- block_out = mem[rd_ptr] when rd_valid=1, otherwise 0. It is driven from registers only.
- Latency: a block written in cycle N shows rd_valid=1 and appears on block_out in cycle N+1 (first-word-fall-through).
- Pointers are AW bits wide and wrap modulo DEPTH with no extra logic.
- count rules per cycle:
  - write only: count+1.
  - read only: count-1.
  - write and read together: count unchanged, both pointers advance.
- Full (count=DEPTH): wr_ready=0 and the write is dropped. A read in the same cycle still completes, so wr_ready=1 from the next cycle.
- Empty (count=0): rd_ready is ignored and nothing changes. A write in the same cycle is stored normally.
- overflow:
  - Set in any cycle where wr_valid=1 and wr_ready=0.
  - Cleared only by RST or clear.
- clear (synchronous, highest priority):
  - Next cycle: pointers=0, count=0, overflow=0.
  - Any write or read in the same cycle is discarded.
  - Storage contents are left unchanged.
- Reset asserted mid-transfer: all state is lost immediately and the FIFO is empty after RST deasserts.

Optional Feature:
Macro: SHA_BLOCK_FIFO_BYPASS_EN.
- Defined: when count=0 and wr_valid && rd_ready are both high:
  - rd_valid=1 and block_out=block_in in the same cycle (zero latency).
  - Nothing is stored and count stays 0.
  - This creates a combinational path from wr_valid/block_in to rd_valid/block_out.
- Undefined: the minimum latency is 1 cycle as described in Behaviour, and there is no input-to-output combinational path.

Decomposition:
- Package sha_block_pkg:
  - Constants SHA_BLOCK_W_352=352 and SHA_BLOCK_W_512=512.
  - Default-depth constant.
  - A typedef for the pointer and count width calculation.
- One sub-module, sha_block_fifo_ctrl, holds the pointer, count, ready/valid and overflow logic.
- The top level holds the storage array and the output mux.

Test Plan:
- Reset then idle: after RST deasserts, count=0, wr_ready=1, rd_valid=0, block_out=0, overflow=0.
- Single pass: write A=352'h1234 in cycle 5 → cycle 6 shows rd_valid=1 and block_out=A; read in cycle 6 → count=0 in cycle 7.
- Fill DEPTH=4 with blocks 1,2,3,4 → wr_ready=0, count=4. A fifth write attempt sets overflow=1, and reads then return 1,2,3,4 in order.
- Wrap-around: run 10 interleaved write/read pairs with writes and reads in the same cycle → count stays constant and the output order matches the input order across pointer wrap.
- Full with simultaneous read: at count=4 drive wr_valid and rd_ready together → read completes, write is dropped, count=3, and wr_ready=1 in the next cycle.
- clear while count=3, asserted together with a write → next cycle count=0, rd_valid=0, overflow=0; a following write of B is read back as B.

Source files
------------

// File: rtl/sha_block_fifo_pkg.sv
// sha_block_pkg: shared widths, default depth and pointer/count sizing for the block FIFO.
package sha_block_pkg;
  localparam int SHA_BLOCK_W_352 = 352;
  localparam int SHA_BLOCK_W_512 = 512;
  localparam int SHA_BLOCK_DEPTH_DEF = 4;
  localparam int SHA_BLOCK_AW_DEF = $clog2(SHA_BLOCK_DEPTH_DEF);
  typedef logic [SHA_BLOCK_AW_DEF-1:0] sha_ptr_t;
  typedef logic [SHA_BLOCK_AW_DEF:0] sha_cnt_t;
  function automatic int sha_ptr_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/sha_block_fifo_if.sv
// sha_block_fifo_if: producer/consumer handshake bundle; slave = FIFO side, master = user side.
interface sha_block_fifo_if import sha_block_pkg::*; #(
  parameter int BLOCK_W = SHA_BLOCK_W_352,
  parameter int DEPTH = SHA_BLOCK_DEPTH_DEF
);
  localparam int AW = sha_ptr_w(DEPTH);
  logic wr_valid, wr_ready, rd_valid, rd_ready, overflow;
  logic [BLOCK_W-1:0] block_in, block_out;
  logic [AW:0] count;
  modport slave (input wr_valid, block_in, rd_ready, output wr_ready, rd_valid, block_out, count, overflow);
  modport master (output wr_valid, block_in, rd_ready, input wr_ready, rd_valid, block_out, count, overflow);
endinterface

// File: rtl/sha_block_fifo_ctrl.sv
// sha_block_fifo_ctrl: pointers, occupancy, ready/valid and sticky overflow for the block FIFO.
// SHA_BLOCK_FIFO_BYPASS_EN adds a zero-latency pass-through when empty.
module sha_block_fifo_ctrl import sha_block_pkg::*; #(
  parameter int DEPTH = SHA_BLOCK_DEPTH_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic wr_valid_i,
  input  logic rd_ready_i,
  output logic wr_en_o,
  output logic byp_o,
  output logic wr_ready_o,
  output logic rd_avail_o,
  output logic overflow_o,
  output logic [sha_ptr_w(DEPTH)-1:0] wr_ptr_o,
  output logic [sha_ptr_w(DEPTH)-1:0] rd_ptr_o,
  output logic [sha_ptr_w(DEPTH):0] count_o
);
  localparam int AW = sha_ptr_w(DEPTH);
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic overflow_q, overflow_d, rd_en;
  assign wr_ready_o = count_q != (AW+1)'(DEPTH);
  assign rd_avail_o = count_q != '0;
`ifdef SHA_BLOCK_FIFO_BYPASS_EN
  assign byp_o = (count_q == '0) && wr_valid_i && rd_ready_i;
`else
  assign byp_o = 1'b0;
`endif
  // a bypassed block is consumed directly and never touches storage
  assign wr_en_o = wr_valid_i && wr_ready_o && !byp_o && !clear;
  assign rd_en = rd_avail_o && rd_ready_i && !clear;
  always_comb begin
    wr_ptr_d = clear ? '0 : wr_ptr_q + AW'(wr_en_o);
    rd_ptr_d = clear ? '0 : rd_ptr_q + AW'(rd_en);
    count_d = clear ? '0 : count_q + (AW+1)'(wr_en_o) - (AW+1)'(rd_en);
    overflow_d = clear ? 1'b0 : overflow_q | (wr_valid_i & ~wr_ready_o);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      overflow_q <= overflow_d;
    end
  end
  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o = count_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/sha_block_fifo.sv
// sha_block_fifo: DEPTH-entry first-word-fall-through buffer of message blocks between expander and round cores.
// SHA_BLOCK_FIFO_BYPASS_EN enables an empty-FIFO combinational pass-through.
module sha_block_fifo import sha_block_pkg::*; #(
  parameter int BLOCK_W = SHA_BLOCK_W_352,
  parameter int DEPTH = SHA_BLOCK_DEPTH_DEF
) (
  input logic CLK,
  input logic RST,
  input logic clear,
  sha_block_fifo_if.slave bus
);
  localparam int AW = sha_ptr_w(DEPTH);
  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic wr_en, byp, rd_avail;
  sha_block_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
    .CLK(CLK),
    .RST(RST),
    .clear(clear),
    .wr_valid_i(bus.wr_valid),
    .rd_ready_i(bus.rd_ready),
    .wr_en_o(wr_en),
    .byp_o(byp),
    .wr_ready_o(bus.wr_ready),
    .rd_avail_o(rd_avail),
    .overflow_o(bus.overflow),
    .wr_ptr_o(wr_ptr),
    .rd_ptr_o(rd_ptr),
    .count_o(bus.count)
  );
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_ptr] <= bus.block_in;
    end
  end
  assign bus.rd_valid = rd_avail | byp;
  assign bus.block_out = byp ? bus.block_in : (rd_avail ? mem_q[rd_ptr] : '0);
endmodule

// File: tb/tb_sha_block_fifo.sv
// tb_sha_block_fifo: directed checks of the block FIFO in its default (no bypass) build.
module tb_sha_block_fifo;
  localparam int W = 352;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic clear = 1'b0;
  int n_tests = 0;
  int n_fail = 0;
  sha_block_fifo_if #(.BLOCK_W(W), .DEPTH(4)) bus ();
  sha_block_fifo #(.BLOCK_W(W), .DEPTH(4)) dut (.CLK(CLK), .RST(RST), .clear(clear), .bus(bus));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // drive one cycle of inputs, return at the following falling edge
  task automatic cyc(input logic wv, input logic [W-1:0] bi, input logic rr, input logic clr);
    bus.wr_valid = wv;
    bus.block_in = bi;
    bus.rd_ready = rr;
    clear = clr;
    @(negedge CLK);
  endtask
  initial begin
    bus.wr_valid = 1'b0;
    bus.block_in = '0;
    bus.rd_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_count", W'(bus.count), 0);
    chk("rst_wr_ready", W'(bus.wr_ready), 1);
    chk("rst_rd_valid", W'(bus.rd_valid), 0);
    chk("rst_block_out", bus.block_out, 0);
    chk("rst_overflow", W'(bus.overflow), 0);
    cyc(1, 352'h1234, 0, 0);
    chk("single_rd_valid", W'(bus.rd_valid), 1);
    chk("single_block_out", bus.block_out, 352'h1234);
    chk("single_count", W'(bus.count), 1);
    cyc(0, 0, 1, 0);
    chk("single_count_after", W'(bus.count), 0);
    chk("single_rd_valid_after", W'(bus.rd_valid), 0);
    chk("single_block_out_after", bus.block_out, 0);
    for (int i = 1; i <= 4; i++) cyc(1, W'(i), 0, 0);
    chk("fill_count", W'(bus.count), 4);
    chk("fill_wr_ready", W'(bus.wr_ready), 0);
    chk("fill_overflow_pre", W'(bus.overflow), 0);
    cyc(1, 5, 0, 0);
    chk("fill_overflow", W'(bus.overflow), 1);
    chk("fill_count_drop", W'(bus.count), 4);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("fill_out%0d", i), bus.block_out, W'(i));
      cyc(0, 0, 1, 0);
    end
    chk("fill_drained", W'(bus.count), 0);
    chk("fill_overflow_sticky", W'(bus.overflow), 1);
    cyc(1, 100, 0, 0);
    cyc(1, 101, 0, 0);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("wrap_head%0d", k), bus.block_out, W'(100 + k));
      cyc(1, W'(102 + k), 1, 0);
      chk($sformatf("wrap_count%0d", k), W'(bus.count), 2);
    end
    chk("wrap_tail0", bus.block_out, 110);
    cyc(0, 0, 1, 0);
    chk("wrap_tail1", bus.block_out, 111);
    cyc(0, 0, 1, 0);
    chk("wrap_empty", W'(bus.count), 0);
    for (int i = 20; i < 24; i++) cyc(1, W'(i), 0, 0);
    chk("fullrd_count4", W'(bus.count), 4);
    cyc(1, 99, 1, 0);
    chk("fullrd_count", W'(bus.count), 3);
    chk("fullrd_wr_ready", W'(bus.wr_ready), 1);
    chk("fullrd_head", bus.block_out, 21);
    cyc(1, 77, 0, 1);
    chk("clear_count", W'(bus.count), 0);
    chk("clear_rd_valid", W'(bus.rd_valid), 0);
    chk("clear_overflow", W'(bus.overflow), 0);
    chk("clear_block_out", bus.block_out, 0);
    cyc(1, 352'hB0B, 0, 0);
    chk("clear_b_out", bus.block_out, 352'hB0B);
    chk("clear_b_count", W'(bus.count), 1);
    cyc(0, 0, 1, 0);
    cyc(0, 0, 1, 0);
    chk("empty_read_count", W'(bus.count), 0);
    chk("empty_read_overflow", W'(bus.overflow), 0);
    cyc(1, 1, 0, 0);
    cyc(1, 2, 0, 0);
    chk("midrst_pre", W'(bus.count), 2);
    bus.wr_valid = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("midrst_count", W'(bus.count), 0);
    chk("midrst_rd_valid", W'(bus.rd_valid), 0);
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("midrst_after_count", W'(bus.count), 0);
    chk("midrst_after_out", bus.block_out, 0);
    chk("midrst_after_wr_ready", W'(bus.wr_ready), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
